// File: rtl/cv_pkg.sv
// Shared types, widths and helpers for the convolution tile scheduler.
package cv_pkg;

  localparam int unsigned CH_W = 11;
  localparam int unsigned SP_W = 8;
  localparam int unsigned K_W  = 5;

  typedef enum logic [3:0] {
    StIdle,
    StCfg,
    StLwReq,
    StLwWait,
    StLifReq,
    StLifWait,
    StCalc,
    StSofReq,
    StSofWait,
    StNext,
    StDone
  } state_e;

  function automatic logic [CH_W-1:0] min_ch(input logic [CH_W-1:0] a,
                                             input logic [CH_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [SP_W-1:0] min_sp(input logic [SP_W-1:0] a,
                                             input logic [SP_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cv_tile_iter.sv
// Nested tile-origin counters (o outermost, then h, then w) stepped by one advance strobe.
module cv_tile_iter
  import cv_pkg::*;
#(
  parameter int unsigned TILE_O  = 16,
  parameter int unsigned TILE_HO = 8,
  parameter int unsigned TILE_WO = 8
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            adv_i,
  input  logic [CH_W-1:0] o_lim_i,
  input  logic [SP_W-1:0] h_lim_i,
  input  logic [SP_W-1:0] w_lim_i,
  output logic [CH_W-1:0] o_ori_o,
  output logic [SP_W-1:0] h_ori_o,
  output logic [SP_W-1:0] w_ori_o,
  output logic            last_o
);

  localparam logic [CH_W:0] OStep = (CH_W + 1)'(TILE_O);
  localparam logic [SP_W:0] HStep = (SP_W + 1)'(TILE_HO);
  localparam logic [SP_W:0] WStep = (SP_W + 1)'(TILE_WO);

  logic [CH_W-1:0] o_q;
  logic [SP_W-1:0] h_q, w_q;
  logic [CH_W:0]   o_next;
  logic [SP_W:0]   h_next, w_next;
  logic            o_wrap, h_wrap, w_wrap;

  // One extra bit so the step past the limit cannot alias back below it.
  assign o_next = {1'b0, o_q} + OStep;
  assign h_next = {1'b0, h_q} + HStep;
  assign w_next = {1'b0, w_q} + WStep;

  assign o_wrap = o_next >= {1'b0, o_lim_i};
  assign h_wrap = h_next >= {1'b0, h_lim_i};
  assign w_wrap = w_next >= {1'b0, w_lim_i};
  assign last_o = o_wrap & h_wrap & w_wrap;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      o_q <= '0;
      h_q <= '0;
      w_q <= '0;
    end else if (clear_i) begin
      o_q <= '0;
      h_q <= '0;
      w_q <= '0;
    end else if (adv_i && !last_o) begin
      if (!w_wrap) begin
        w_q <= w_next[SP_W-1:0];
      end else begin
        w_q <= '0;
        if (!h_wrap) begin
          h_q <= h_next[SP_W-1:0];
        end else begin
          h_q <= '0;
          o_q <= o_next[CH_W-1:0];
        end
      end
    end
  end

  assign o_ori_o = o_q;
  assign h_ori_o = h_q;
  assign w_ori_o = w_q;

endmodule

// File: rtl/cv_tile_scheduler.sv
// Walks one conv layer in output tiles and sequences loader / core commands per tile.
// Optional perf counters are enabled by defining CV_TILE_PERF_CNT_EN.
module cv_tile_scheduler
  import cv_pkg::*;
#(
  parameter int unsigned TILE_O  = 16,
  parameter int unsigned TILE_HO = 8,
  parameter int unsigned TILE_WO = 8
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [CH_W-1:0] I_i,
  input  logic [CH_W-1:0] O_i,
  input  logic [K_W-1:0]  K_i,
  input  logic [CH_W-1:0] H_i,
  input  logic [CH_W-1:0] W_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [CH_W-1:0] Oori_o,
  output logic [SP_W-1:0] Hori_o,
  output logic [SP_W-1:0] Wori_o,
  output logic [CH_W-1:0] Oext_o,
  output logic [SP_W-1:0] Hext_o,
  output logic [SP_W-1:0] Wext_o,
  output logic            load_weight_o,
  output logic            load_input_o,
  output logic            store_output_o,
  input  logic            ldr_done_i,
  output logic            core_start_o
`ifdef CV_TILE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_cycles_o,
  output logic [31:0]     perf_tiles_o,
  output logic [31:0]     perf_wait_o
`endif
);

  localparam logic [CH_W-1:0] OTile = CH_W'(TILE_O);
  localparam logic [SP_W-1:0] HTile = SP_W'(TILE_HO);
  localparam logic [SP_W-1:0] WTile = SP_W'(TILE_WO);

  state_e          state_q, state_d;
  logic [CH_W-1:0] o_lim_q;
  logic [K_W-1:0]  k_q;
  logic [SP_W-1:0] hout_q, wout_q;
  logic [CH_W-1:0] oext_q;
  logic [SP_W-1:0] hext_q, wext_q;
  logic            err_q;

  logic [CH_W-1:0] k_ext, hout_w, wout_w;
  logic            cfg_bad, accept, last_tile;
  logic [CH_W-1:0] o_ori;
  logic [SP_W-1:0] h_ori, w_ori;

  assign k_ext  = CH_W'(K_i);
  assign hout_w = H_i - k_ext + 11'd1;
  assign wout_w = W_i - k_ext + 11'd1;
  assign cfg_bad = (K_i == '0) || (k_ext > H_i) || (k_ext > W_i) || (I_i == '0) ||
                   (O_i == '0) || (hout_w > 11'd255) || (wout_w > 11'd255);
  assign accept = (state_q == StIdle) && start_i;

  cv_tile_iter #(
    .TILE_O (TILE_O),
    .TILE_HO(TILE_HO),
    .TILE_WO(TILE_WO)
  ) u_iter (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .clear_i(accept),
    .adv_i  (state_q == StNext),
    .o_lim_i(o_lim_q),
    .h_lim_i(hout_q),
    .w_lim_i(wout_q),
    .o_ori_o(o_ori),
    .h_ori_o(h_ori),
    .w_ori_o(w_ori),
    .last_o (last_tile)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_i) state_d = cfg_bad ? StDone : StCfg;
      StCfg:     state_d = (h_ori == '0 && w_ori == '0) ? StLwReq : StLifReq;
      StLwReq:   state_d = StLwWait;
      StLwWait:  if (ldr_done_i) state_d = StLifReq;
      StLifReq:  state_d = StLifWait;
      StLifWait: if (ldr_done_i) state_d = StCalc;
      StCalc:    state_d = StSofReq;
      StSofReq:  state_d = StSofWait;
      StSofWait: if (ldr_done_i) state_d = StNext;
      StNext:    state_d = last_tile ? StDone : StCfg;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      o_lim_q <= '0;
      k_q     <= '0;
      hout_q  <= '0;
      wout_q  <= '0;
      oext_q  <= '0;
      hext_q  <= '0;
      wext_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        o_lim_q <= O_i;
        k_q     <= K_i;
        hout_q  <= hout_w[SP_W-1:0];
        wout_q  <= wout_w[SP_W-1:0];
        err_q   <= cfg_bad;
      end
      // Extents include the K-1 halo the loader needs on the input side.
      if (state_q == StCfg) begin
        oext_q <= min_ch(OTile, o_lim_q - o_ori);
        hext_q <= min_sp(HTile, hout_q - h_ori) + SP_W'(k_q) - 8'd1;
        wext_q <= min_sp(WTile, wout_q - w_ori) + SP_W'(k_q) - 8'd1;
      end
    end
  end

  assign busy_o         = (state_q != StIdle) && (state_q != StDone);
  assign done_o         = (state_q == StDone);
  assign err_o          = err_q;
  assign load_weight_o  = (state_q == StLwReq);
  assign load_input_o   = (state_q == StLifReq);
  assign core_start_o   = (state_q == StCalc);
  assign store_output_o = (state_q == StSofReq);
  assign Oori_o         = o_ori;
  assign Hori_o         = h_ori;
  assign Wori_o         = w_ori;
  assign Oext_o         = oext_q;
  assign Hext_o         = hext_q;
  assign Wext_o         = wext_q;

`ifdef CV_TILE_PERF_CNT_EN
  logic [31:0] perf_cycles_q, perf_tiles_q, perf_wait_q;
  logic        waiting;

  // The cycle on which ldr_done arrives is a working cycle, not a wait cycle.
  assign waiting = ((state_q == StLwWait) || (state_q == StLifWait) ||
                    (state_q == StSofWait)) && !ldr_done_i;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_tiles_q  <= '0;
      perf_wait_q   <= '0;
    end else if (accept) begin
      perf_cycles_q <= '0;
      perf_tiles_q  <= '0;
      perf_wait_q   <= '0;
    end else begin
      if (busy_o && !(&perf_cycles_q)) perf_cycles_q <= perf_cycles_q + 32'd1;
      if ((state_q == StNext) && !(&perf_tiles_q)) perf_tiles_q <= perf_tiles_q + 32'd1;
      if (waiting && !(&perf_wait_q)) perf_wait_q <= perf_wait_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_tiles_o  = perf_tiles_q;
  assign perf_wait_o   = perf_wait_q;
`endif

endmodule

// File: tb/tb_cv_tile_scheduler.sv
// Self-checking bench: an event-queue model of the tile walk checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_cv_tile_scheduler;

  localparam int TO  = 16;
  localparam int THO = 8;
  localparam int TWO = 8;
  localparam int EvLw = 0, EvLif = 1, EvCs = 2, EvSof = 3, EvDone = 4;

  typedef struct {
    int kind;
    int oo, ho, wo, oe, he, we;
  } ev_t;

  logic        clk_i, rst_n, start_i, ldr_done_i;
  logic [10:0] I_i, O_i, H_i, W_i;
  logic [4:0]  K_i;
  logic        busy_o, done_o, err_o;
  logic [10:0] Oori_o, Oext_o;
  logic [7:0]  Hori_o, Wori_o, Hext_o, Wext_o;
  logic        load_weight_o, load_input_o, store_output_o, core_start_o;
`ifdef CV_TILE_PERF_CNT_EN
  logic [31:0] perf_cycles_o, perf_tiles_o, perf_wait_o;
`endif

  cv_tile_scheduler #(
    .TILE_O (TO),
    .TILE_HO(THO),
    .TILE_WO(TWO)
  ) dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .I_i           (I_i),
    .O_i           (O_i),
    .K_i           (K_i),
    .H_i           (H_i),
    .W_i           (W_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .Oori_o        (Oori_o),
    .Hori_o        (Hori_o),
    .Wori_o        (Wori_o),
    .Oext_o        (Oext_o),
    .Hext_o        (Hext_o),
    .Wext_o        (Wext_o),
    .load_weight_o (load_weight_o),
    .load_input_o  (load_input_o),
    .store_output_o(store_output_o),
    .ldr_done_i    (ldr_done_i),
    .core_start_o  (core_start_o)
`ifdef CV_TILE_PERF_CNT_EN
    ,
    .perf_cycles_o (perf_cycles_o),
    .perf_tiles_o  (perf_tiles_o),
    .perf_wait_o   (perf_wait_o)
`endif
  );

  int  n_pass, n_total;
  bit  chk_en, done_cycle, mdl_err;
  ev_t q[$];
  int  ldr_delay;
  bit  ldr_hold;

  int r_lw, r_core, r_first_lw, r_done_at, r_err;
  int r_oori, r_hori, r_wori, r_oext, r_hext, r_wext;
  int r_f_oori, r_f_hori, r_f_wori;
  longint r_pc, r_pt, r_pw;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Expected command stream for a whole layer, straight from the loop-nest rules.
  task automatic build(input int o, input int i, input int k, input int h, input int w);
    int  hout, wout;
    bit  bad;
    ev_t e;
    hout = h - k + 1;
    wout = w - k + 1;
    bad = (k == 0) || (k > h) || (k > w) || (i == 0) || (o == 0) || (hout > 255) ||
          (wout > 255);
    q.delete();
    mdl_err = bad;
    e = '{EvDone, 0, 0, 0, 0, 0, 0};
    if (!bad) begin
      for (int oo = 0; oo < o; oo += TO) begin
        for (int hh = 0; hh < hout; hh += THO) begin
          for (int ww = 0; ww < wout; ww += TWO) begin
            e.oo = oo; e.ho = hh; e.wo = ww;
            e.oe = imin(TO, o - oo);
            e.he = imin(THO, hout - hh) + k - 1;
            e.we = imin(TWO, wout - ww) + k - 1;
            if (hh == 0 && ww == 0) begin e.kind = EvLw; q.push_back(e); end
            e.kind = EvLif; q.push_back(e);
            e.kind = EvCs;  q.push_back(e);
            e.kind = EvSof; q.push_back(e);
          end
        end
      end
    end
    e.kind = EvDone;
    q.push_back(e);
  endtask

  // Model side: a start is taken only when no layer is outstanding.
  always @(posedge clk_i) begin
    if (!rst_n) begin
      q.delete();
      mdl_err = 1'b0;
    end else if (chk_en && start_i && q.size() == 0 && !done_cycle) begin
      build(int'(O_i), int'(I_i), int'(K_i), int'(H_i), int'(W_i));
    end
    done_cycle = 1'b0;
  end

  always @(negedge clk_i) begin
    int  kind, ncmd;
    ev_t e;
    if (chk_en && rst_n) begin
      ncmd = int'(load_weight_o) + int'(load_input_o) + int'(core_start_o) +
             int'(store_output_o) + int'(done_o);
      kind = load_weight_o ? EvLw : load_input_o ? EvLif : core_start_o ? EvCs :
             store_output_o ? EvSof : EvDone;
      if (ncmd > 1) begin
        check("cmd_onehot", ncmd, 1);
      end else if (ncmd == 1) begin
        if (q.size() == 0) begin
          check("cmd_unexpected", kind, -1);
        end else begin
          e = q.pop_front();
          check("cmd_order", kind, e.kind);
          if (kind == EvDone) begin
            done_cycle = 1'b1;
          end else begin
            check("tile_oori", Oori_o, e.oo);
            check("tile_hori", Hori_o, e.ho);
            check("tile_wori", Wori_o, e.wo);
            check("tile_oext", Oext_o, e.oe);
            check("tile_hext", Hext_o, e.he);
            check("tile_wext", Wext_o, e.we);
          end
        end
      end
      check("busy", busy_o, q.size() != 0);
      check("err", err_o, mdl_err);
    end
  end

  // Loader stand-in: ldr_done arrives after ldr_delay full wait cycles, or is held high.
  initial begin
    int pend;
    pend = 0;
    ldr_done_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_n) begin
        pend = 0;
        ldr_done_i = 1'b0;
      end else if (ldr_hold) begin
        ldr_done_i = 1'b1;
      end else begin
        ldr_done_i = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) ldr_done_i = 1'b1;
        end
        if (load_weight_o || load_input_o || store_output_o) pend = ldr_delay + 1;
      end
    end
  end

  task automatic check_all_zero(input string name);
    check(name, longint'({busy_o, done_o, err_o, load_weight_o, load_input_o, core_start_o,
                          store_output_o, Oori_o, Hori_o, Wori_o, Oext_o, Hext_o, Wext_o}),
          0);
  endtask

  task automatic run_layer(input int o, input int i, input int k, input int h, input int w,
                           input int dly, input bit hold, input bit dbl);
    O_i = 11'(o); I_i = 11'(i); K_i = 5'(k); H_i = 11'(h); W_i = 11'(w);
    ldr_delay = dly;
    ldr_hold  = hold;
    r_lw = 0; r_core = 0; r_first_lw = -1; r_done_at = -1; r_err = -1;
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    for (int n = 1; n <= 5000; n++) begin
      @(negedge clk_i);
      if (dbl) begin
        start_i = (n == 4);
        if (n == 4) O_i = 11'd1;
      end
      if (load_weight_o) begin
        r_lw++;
        if (r_first_lw < 0) r_first_lw = n;
      end
      if (core_start_o) begin
        r_core++;
        r_oori = int'(Oori_o); r_hori = int'(Hori_o); r_wori = int'(Wori_o);
        r_oext = int'(Oext_o); r_hext = int'(Hext_o); r_wext = int'(Wext_o);
        if (r_core == 1) begin
          r_f_oori = r_oori; r_f_hori = r_hori; r_f_wori = r_wori;
        end
      end
      if (done_o) begin
        r_done_at = n;
        r_err = int'(err_o);
`ifdef CV_TILE_PERF_CNT_EN
        r_pc = perf_cycles_o; r_pt = perf_tiles_o; r_pw = perf_wait_o;
`endif
        break;
      end
    end
    start_i  = 1'b0;
    ldr_hold = 1'b0;
    if (r_done_at < 0) check("layer_timeout", 0, 1);
  endtask

  initial begin
    int cnt;
    n_pass = 0; n_total = 0; chk_en = 1'b0; done_cycle = 1'b0; mdl_err = 1'b0;
    start_i = 1'b0; ldr_delay = 0; ldr_hold = 1'b0; rst_n = 1'b0;
    I_i = '0; O_i = '0; K_i = '0; H_i = '0; W_i = '0;
    r_pc = 0; r_pt = 0; r_pw = 0;
    repeat (3) @(posedge clk_i);
    #1 check_all_zero("reset_outputs");
    @(negedge clk_i);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single tile.
    run_layer(4, 2, 3, 6, 6, 3, 1'b0, 1'b0);
    check("t1_lw_latency", r_first_lw, 2);
    check("t1_lw_count", r_lw, 1);
    check("t1_core_count", r_core, 1);
    check("t1_oext", r_oext, 4);
    check("t1_hext", r_hext, 6);
    check("t1_wext", r_wext, 6);
    check("t1_err", r_err, 0);

    // 2x3x3 tiles with clipped edges.
    run_layer(20, 1, 3, 20, 20, 1, 1'b0, 1'b0);
    check("t2_lw_count", r_lw, 2);
    check("t2_core_count", r_core, 18);
    check("t2_last_oori", r_oori, 16);
    check("t2_last_oext", r_oext, 4);
    check("t2_last_hori", r_hori, 16);
    check("t2_last_hext", r_hext, 4);

    // Kernel taller than the input.
    run_layer(4, 2, 7, 5, 5, 2, 1'b0, 1'b0);
    check("t3_done_latency", r_done_at, 1);
    check("t3_err", r_err, 1);
    check("t3_lw_count", r_lw, 0);
    check("t3_core_count", r_core, 0);

    // ldr_done held high, plus a second start and a config change while busy.
    run_layer(20, 1, 3, 10, 10, 0, 1'b1, 1'b1);
    check("t4_lw_count", r_lw, 2);
    check("t4_core_count", r_core, 2);
    check("t4_err_cleared", r_err, 0);

    // Fixed 10-cycle loader latency on the single-tile case.
    run_layer(4, 2, 3, 6, 6, 10, 1'b0, 1'b0);
    check("t5_core_count", r_core, 1);
`ifdef CV_TILE_PERF_CNT_EN
    check("t5_perf_tiles", r_pt, 1);
    check("t5_perf_wait", r_pw, 30);
    check("t5_perf_cycles", r_pc, 39);
`endif

    // Async reset in the LIF_WAIT of the third tile, then a clean rerun.
    O_i = 11'd20; I_i = 11'd1; K_i = 5'd3; H_i = 11'd20; W_i = 11'd20;
    ldr_delay = 4;
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    cnt = 0;
    for (int n = 0; n < 2000 && cnt < 3; n++) begin
      @(negedge clk_i);
      if (load_input_o) cnt++;
    end
    check("t6_reached_lif", cnt, 3);
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1 check_all_zero("t6_async_reset_outputs");
    @(posedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b1;
    chk_en = 1'b1;
    run_layer(20, 1, 3, 20, 20, 1, 1'b0, 1'b0);
    check("t6_first_oori", r_f_oori, 0);
    check("t6_first_hori", r_f_hori, 0);
    check("t6_first_wori", r_f_wori, 0);
    check("t6_core_count", r_core, 18);

    repeat (3) @(negedge clk_i);
    check("model_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
